// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Round sequencing FSM for an iterative AES datapath; optional
//            counter consistency checker enabled by AES_RND_CTRL_CHK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
    parameter int MAX_CNT  = 11,
    parameter int CNT_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start_valid,
    output logic                o_start_ready,
    input  logic [CNT_SIZE-1:0] i_count,
    input  logic                i_flag,
    output logic                o_cnt_en,
    output logic                o_cnt_clr,
    output logic                o_load,
    output logic                o_sel_init,
    output logic                o_sel_final,
    output logic [CNT_SIZE-1:0] o_round_idx,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic                o_busy,
    output logic                o_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [CNT_SIZE-1:0] C_CNT_PEN  = CNT_SIZE'(MAX_CNT - 2);
    localparam logic [CNT_SIZE-1:0] C_CNT_LAST = CNT_SIZE'(MAX_CNT - 1);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output except the counter clear is forced low while in reset.
    always_comb begin
        state_d       = state_q;
        o_start_ready = 1'b0;
        o_cnt_en      = 1'b0;
        o_cnt_clr     = rst;
        o_load        = 1'b0;
        o_sel_init    = 1'b0;
        o_sel_final   = 1'b0;
        o_round_idx   = '0;
        o_out_valid   = 1'b0;
        o_busy        = 1'b0;
        if (!rst) begin
            o_busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    o_start_ready = 1'b1;
                    if (i_start_valid) begin
                        o_cnt_clr = 1'b1;
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    o_load      = 1'b1;
                    o_sel_init  = 1'b1;
                    o_cnt_en    = 1'b1;
                    o_round_idx = i_count;
                    state_d     = ROUND;
                end
                ROUND: begin
                    o_cnt_en    = 1'b1;
                    o_round_idx = i_count;
                    if (i_count == C_CNT_PEN) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    o_sel_final = 1'b1;
                    o_round_idx = i_count;
                    state_d     = HOLD;
                end
                HOLD: begin
                    o_out_valid = 1'b1;
                    if (i_out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef AES_RND_CTRL_CHK_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = 1'b0;
        case (state_q)
            LOAD:    err_d = (i_count != '0);
            ROUND:   err_d = i_flag;
            FINAL:   err_d = !i_flag || (i_count != C_CNT_LAST);
            default: err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_d) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q && !rst;
`else
    // The terminal flag only feeds the checker.
    logic w_unused_flag;
    assign w_unused_flag = i_flag;
    assign o_err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Self-checking bench for aes_round_ctrl against a timeline model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aes_round_ctrl;
    localparam int MAX = 11;
    localparam int CW  = 4;
`ifdef AES_RND_CTRL_CHK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start_valid = 1'b0;
    logic          i_out_ready = 1'b0;
    logic          force_flag = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic [CW-1:0] i_count;
    logic          i_flag;
    logic          o_start_ready, o_cnt_en, o_cnt_clr, o_load, o_sel_init;
    logic          o_sel_final, o_out_valid, o_busy, o_err;
    logic [CW-1:0] o_round_idx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int k = 0;          // cycles since accept; 0 means idle
    bit err_m = 1'b0;
    int last_acc = 0, acc_gap = 0, v_start = 0, xfers = 0, accepts = 0;
    bit prev_v = 1'b0;
    logic [CW-1:0] idxq[$];
    logic [CW-1:0] last_seq[$];

    aes_round_ctrl #(.MAX_CNT(MAX), .CNT_SIZE(CW)) dut (
        .clk(clk), .rst(rst),
        .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
        .i_count(i_count), .i_flag(i_flag),
        .o_cnt_en(o_cnt_en), .o_cnt_clr(o_cnt_clr), .o_load(o_load),
        .o_sel_init(o_sel_init), .o_sel_final(o_sel_final),
        .o_round_idx(o_round_idx), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Round counter the controller drives.
    assign i_count = cnt;
    assign i_flag  = (cnt == CW'(MAX - 1)) || force_flag;
    always @(posedge clk) begin
        if (o_cnt_clr)     cnt <= '0;
        else if (o_cnt_en) cnt <= cnt + 1'b1;
    end

    // Timeline model: LOAD at k=1, ROUND k=2..MAX-1, FINAL k=MAX, HOLD after.
    always @(posedge clk) begin
        if (rst) begin
            k     <= 0;
            err_m <= 1'b0;
        end else begin
            if (k == 1 && i_count != 0) err_m <= 1'b1;
            if (k >= 2 && k <= MAX - 1 && i_flag) err_m <= 1'b1;
            if (k == MAX && (!i_flag || i_count != MAX - 1)) err_m <= 1'b1;
            if (k == 0) begin
                if (i_start_valid) k <= 1;
            end else if (k <= MAX) begin
                k <= k + 1;
            end else if (i_out_ready) begin
                k <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit live;
        live = !rst;
        chk("start_ready", o_start_ready, int'(live && k == 0));
        chk("cnt_clr",     o_cnt_clr,     int'(rst || (k == 0 && i_start_valid)));
        chk("load",        o_load,        int'(live && k == 1));
        chk("sel_init",    o_sel_init,    int'(live && k == 1));
        chk("cnt_en",      o_cnt_en,      int'(live && k >= 1 && k <= MAX - 1));
        chk("sel_final",   o_sel_final,   int'(live && k == MAX));
        chk("out_valid",   o_out_valid,   int'(live && k > MAX));
        chk("busy",        o_busy,        int'(live && k != 0));
        chk("round_idx",   o_round_idx,   (live && k >= 1 && k <= MAX) ? k - 1 : 0);
        chk("err",         o_err,         (EXP_ERR != 0 && live && err_m) ? 1 : 0);
    end

    // Transaction monitor (samples pre-edge values).
    always @(posedge clk) begin
        if (!rst && o_start_ready && i_start_valid) begin
            acc_gap  = cyc - last_acc;
            last_acc = cyc;
            accepts++;
            if (idxq.size() > 0) last_seq = idxq;
            idxq.delete();
        end else if (!rst && (o_cnt_en || o_sel_final)) begin
            idxq.push_back(o_round_idx);
        end
        if (!rst && o_out_valid && i_out_ready) xfers++;
        if (o_out_valid && !prev_v) v_start = cyc;
        prev_v = o_out_valid;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic start_op();
        i_start_valid = 1'b1;
        tick();
        i_start_valid = 1'b0;
    endtask

    initial begin
        int n, x0, a0;
        bit rdy_seen;

        repeat (3) tick();
        chk("rst_clr_lit", o_cnt_clr, 1);
        chk("rst_ready_lit", o_start_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst_lit", o_start_ready, 1);
        tick();

        // Single op, result accepted on entry to HOLD
        i_out_ready = 1'b1;
        x0 = xfers;
        start_op();
        wait_valid();
        tick();
        chk("latency_lit", v_start - last_acc, 12);
        chk("single_valid_cycle", o_out_valid, 0);
        chk("single_xfer", xfers - x0, 1);
        tick();

        // Backpressure for 5 cycles
        i_out_ready = 1'b0;
        x0 = xfers;
        start_op();
        wait_valid();
        n = 0;
        rdy_seen = 1'b0;
        repeat (5) begin
            if (o_out_valid) n++;
            if (o_start_ready) rdy_seen = 1'b1;
            tick();
        end
        i_out_ready = 1'b1;
        if (o_out_valid) n++;
        tick();
        chk("bp_valid_cycles", n, 6);
        chk("bp_ready_low", rdy_seen, 0);
        chk("bp_valid_drop", o_out_valid, 0);
        chk("bp_one_xfer", xfers - x0, 1);
        tick();

        // Start pulsed while busy is ignored
        a0 = accepts;
        start_op();
        repeat (3) tick();
        start_op();
        wait_valid();
        tick();
        chk("busy_start_latency", v_start - last_acc, 12);
        chk("busy_start_ignored", accepts - a0, 1);
        start_op();
        wait_valid();
        tick();
        chk("restart_latency", v_start - last_acc, 12);
        tick();

        // Reset in the middle of an operation
        start_op();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midrst_clr", o_cnt_clr, 1);
        chk("midrst_busy", o_busy, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_ready", o_start_ready, 1);
        start_op();
        wait_valid();
        tick();
        chk("post_rst_latency", v_start - last_acc, 12);
        tick();

        // Corrupt the terminal flag during ROUND
        start_op();
        repeat (2) tick();
        force_flag = 1'b1;
        tick();
        force_flag = 1'b0;
        wait_valid();
        tick();
        chk("err_sticky_lit", o_err, EXP_ERR);
        repeat (2) tick();
        chk("err_still_set_lit", o_err, EXP_ERR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("err_cleared_lit", o_err, 0);
        tick();

        // Back-to-back operation
        i_start_valid = 1'b1;
        i_out_ready   = 1'b1;
        repeat (45) tick();
        i_start_valid = 1'b0;
        chk("b2b_gap_lit", acc_gap, 13);
        chk("b2b_seq_len", last_seq.size(), 11);
        for (int i = 0; i < 11 && i < last_seq.size(); i++)
            chk($sformatf("b2b_idx%0d", i), last_seq[i], i);
        repeat (20) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_start_valid = 1'($urandom_range(0, 1));
            i_out_ready   = ($urandom % 3) != 0;
            rst           = ($urandom % 200) == 0;
            force_flag    = ($urandom % 100) == 0;
            tick();
        end
        rst = 1'b0;
        force_flag = 1'b0;
        i_start_valid = 1'b0;
        i_out_ready = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
